// File: rtl/bsg_dmc_pkg.sv
// Shared types for the bsg_dmc user-interface logic: app command encoding and
// the UI arbiter state enum.
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    e_app_wr = 3'b000,
    e_app_rd = 3'b001
  } app_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } bsg_dmc_ui_arb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready on the write side and valid/yumi
// on the read side. A full FIFO refuses a push even if a pop occurs in the same cycle.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 2,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p - 1);
  localparam logic [ptr_width_lp:0]   count_full_lp = (ptr_width_lp + 1)'(els_p);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ptr_width_lp:0]   count_q, count_d;
  logic                    push, pop;

  assign ready_o = (count_q != count_full_lp);
  assign v_o     = (count_q != '0);
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == ptr_last_lp) ? '0 : wptr_q + ptr_width_lp'(1);
    if (pop)  rptr_d = (rptr_q == ptr_last_lp) ? '0 : rptr_q + ptr_width_lp'(1);
    if (push && !pop)      count_d = count_q + (ptr_width_lp + 1)'(1);
    else if (pop && !push) count_d = count_q - (ptr_width_lp + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_dmc_ui_arbiter.sv
// Round-robin arbiter sharing one bsg_dmc app interface among several requesters;
// write bursts are streamed atomically and read data is steered back by an ID FIFO.
module bsg_dmc_ui_arbiter
  import bsg_dmc_pkg::*;
#(
  parameter int num_req_p         = 4,
  parameter int ui_addr_width_p   = 28,
  parameter int ui_data_width_p   = 32,
  parameter int ui_burst_length_p = 8,
  parameter int rd_id_depth_p     = 8
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      init_calib_complete_i,
  input  logic                                      refresh_in_progress_i,
  input  logic [num_req_p-1:0]                      req_v_i,
  input  logic [num_req_p*3-1:0]                    req_cmd_i,
  input  logic [num_req_p*ui_addr_width_p-1:0]      req_addr_i,
  output logic [num_req_p-1:0]                      req_yumi_o,
  input  logic [num_req_p*ui_data_width_p-1:0]      req_wdata_i,
  input  logic [num_req_p*(ui_data_width_p>>3)-1:0] req_wmask_i,
  input  logic [num_req_p-1:0]                      req_wdata_v_i,
  output logic [num_req_p-1:0]                      req_wdata_yumi_o,
  output logic [ui_data_width_p-1:0]                rd_data_o,
  output logic [num_req_p-1:0]                      rd_data_v_o,
  output logic                                      rd_data_end_o,
  output logic [ui_addr_width_p-1:0]                app_addr_o,
  output logic [2:0]                                app_cmd_o,
  output logic                                      app_en_o,
  input  logic                                      app_rdy_i,
  output logic                                      app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]                app_wdf_data_o,
  output logic [(ui_data_width_p>>3)-1:0]           app_wdf_mask_o,
  output logic                                      app_wdf_end_o,
  input  logic                                      app_wdf_rdy_i,
  input  logic                                      app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]                app_rd_data_i,
  input  logic                                      app_rd_data_end_i,
  output logic                                      rd_orphan_o
);

  localparam int id_width_lp   = $clog2(num_req_p);
  localparam int mask_width_lp = ui_data_width_p >> 3;
  localparam int beat_width_lp = (ui_burst_length_p > 1) ? $clog2(ui_burst_length_p) : 1;
  localparam logic [beat_width_lp-1:0] last_beat_lp = beat_width_lp'(ui_burst_length_p - 1);

  bsg_dmc_ui_arb_state_e state_q, state_d;
  app_cmd_e                   cmd_q, cmd_d;
  logic [id_width_lp-1:0]     id_q, id_d, rr_q, rr_d, grant_id;
  logic [ui_addr_width_p-1:0] addr_q, addr_d;
  logic [beat_width_lp-1:0]   beat_q, beat_d;
  logic                       orphan_q, orphan_d;

  logic [2:0]                 cmd_a   [num_req_p];
  logic [ui_addr_width_p-1:0] addr_a  [num_req_p];
  logic [ui_data_width_p-1:0] wdata_a [num_req_p];
  logic [mask_width_lp-1:0]   wmask_a [num_req_p];
  logic [num_req_p-1:0]       elig;
  logic                       grant_v;

  logic                   fifo_ready, fifo_v, fifo_push, fifo_pop;
  logic [id_width_lp-1:0] fifo_id;

  // Anything other than WR is issued as a read, so it needs an ID FIFO slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cmd_a[i]   = req_cmd_i[i*3 +: 3];
      addr_a[i]  = req_addr_i[i*ui_addr_width_p +: ui_addr_width_p];
      wdata_a[i] = req_wdata_i[i*ui_data_width_p +: ui_data_width_p];
      wmask_a[i] = req_wmask_i[i*mask_width_lp +: mask_width_lp];
      elig[i]    = req_v_i[i] & ((cmd_a[i] == e_app_wr) | fifo_ready);
    end
  end

  // Lowest eligible index above the RR pointer wins; otherwise the lowest overall.
  always_comb begin
    grant_v  = |elig;
    grant_id = '0;
    for (int i = num_req_p - 1; i >= 0; i--)
      if (elig[i]) grant_id = id_width_lp'(i);
    for (int i = num_req_p - 1; i >= 0; i--)
      if (elig[i] && (i > int'(rr_q))) grant_id = id_width_lp'(i);
  end

  always_comb begin
    state_d          = state_q;
    id_d             = id_q;
    cmd_d            = cmd_q;
    addr_d           = addr_q;
    rr_d             = rr_q;
    beat_d           = beat_q;
    req_yumi_o       = '0;
    req_wdata_yumi_o = '0;
    app_en_o         = 1'b0;
    app_wdf_wren_o   = 1'b0;
    app_wdf_end_o    = 1'b0;
    app_wdf_data_o   = '0;
    app_wdf_mask_o   = '0;
    fifo_push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_calib_complete_i && !refresh_in_progress_i && grant_v) begin
          id_d    = grant_id;
          cmd_d   = (cmd_a[grant_id] == e_app_wr) ? e_app_wr : e_app_rd;
          addr_d  = addr_a[grant_id];
          state_d = CMD;
        end
      end
      CMD: begin
        app_en_o = 1'b1;
        if (app_rdy_i) begin
          req_yumi_o[id_q] = 1'b1;
          rr_d             = id_q;
          if (cmd_q == e_app_wr) begin
            beat_d  = '0;
            state_d = WDATA;
          end else begin
            fifo_push = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WDATA: begin
        app_wdf_wren_o = req_wdata_v_i[id_q];
        app_wdf_data_o = wdata_a[id_q];
        app_wdf_mask_o = wmask_a[id_q];
        app_wdf_end_o  = (beat_q == last_beat_lp);
        if (app_wdf_wren_o && app_wdf_rdy_i) begin
          req_wdata_yumi_o[id_q] = 1'b1;
          beat_d                 = beat_q + beat_width_lp'(1);
          if (beat_q == last_beat_lp) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      id_q     <= '0;
      cmd_q    <= e_app_wr;
      addr_q   <= '0;
      rr_q     <= '0;
      beat_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      orphan_q <= orphan_d;
    end
  end

  assign app_addr_o = addr_q;
  assign app_cmd_o  = cmd_q;

  bsg_fifo_1r1w_small #(
    .width_p(id_width_lp),
    .els_p  (rd_id_depth_p)
  ) rd_id_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (fifo_push),
    .ready_o(fifo_ready),
    .data_i (id_q),
    .v_o    (fifo_v),
    .data_o (fifo_id),
    .yumi_i (fifo_pop)
  );

  // The DMC returns reads in order, so the FIFO head owns the current burst.
  always_comb begin
    rd_data_v_o = '0;
    if (fifo_v && app_rd_data_valid_i) rd_data_v_o[fifo_id] = 1'b1;
  end

  assign rd_data_o     = app_rd_data_i;
  assign rd_data_end_o = app_rd_data_end_i;
  assign fifo_pop      = fifo_v & app_rd_data_valid_i & app_rd_data_end_i;
  assign orphan_d      = orphan_q | (app_rd_data_valid_i & ~fifo_v);
  assign rd_orphan_o   = orphan_q;

  for (genvar g = 0; g < num_req_p; g++) begin : g_cmd_legal
    assert property (@(posedge clk_i) disable iff (reset_i)
      req_v_i[g] |-> (req_cmd_i[g*3 +: 3] inside {e_app_wr, e_app_rd}));
  end

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// Directed bench for bsg_dmc_ui_arbiter: queued requester models, a simple DMC
// model and scoreboards for commands, write beats and read-return steering.
module tb_bsg_dmc_ui_arbiter;
  import bsg_dmc_pkg::*;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MW = DW >> 3;
  localparam int BL = 8;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            init_calib_complete_i, refresh_in_progress_i;
  logic [N-1:0]    req_v_i, req_yumi_o, req_wdata_v_i, req_wdata_yumi_o, rd_data_v_o;
  logic [N*3-1:0]  req_cmd_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N*MW-1:0] req_wmask_i;
  logic [DW-1:0]   rd_data_o, app_wdf_data_o, app_rd_data_i;
  logic            rd_data_end_o, app_en_o, app_rdy_i, app_wdf_wren_o, app_wdf_end_o;
  logic            app_wdf_rdy_i, app_rd_data_valid_i, app_rd_data_end_i, rd_orphan_o;
  logic [AW-1:0]   app_addr_o;
  logic [2:0]      app_cmd_o;
  logic [MW-1:0]   app_wdf_mask_o;

  always #5 clk_i = ~clk_i;

  bsg_dmc_ui_arbiter #(
    .num_req_p(N), .ui_addr_width_p(AW), .ui_data_width_p(DW),
    .ui_burst_length_p(BL), .rd_id_depth_p(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .init_calib_complete_i(init_calib_complete_i),
    .refresh_in_progress_i(refresh_in_progress_i),
    .req_v_i(req_v_i), .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i),
    .req_yumi_o(req_yumi_o), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .req_wdata_v_i(req_wdata_v_i), .req_wdata_yumi_o(req_wdata_yumi_o),
    .rd_data_o(rd_data_o), .rd_data_v_o(rd_data_v_o), .rd_data_end_o(rd_data_end_o),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
    .app_rdy_i(app_rdy_i), .app_wdf_wren_o(app_wdf_wren_o),
    .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
    .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
    .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
    .app_rd_data_end_i(app_rd_data_end_i), .rd_orphan_o(rd_orphan_o)
  );

  typedef struct {logic [2:0] cmd; logic [AW-1:0] addr;} rq_t;
  typedef struct {logic [DW-1:0] d; logic [MW-1:0] m;} beat_t;
  typedef struct {int id; logic [2:0] cmd; logic [AW-1:0] addr;} exp_cmd_t;
  typedef struct {int id; logic [DW-1:0] d; logic [MW-1:0] m; logic last;} exp_w_t;

  rq_t      rq_q [N][$];
  beat_t    bq   [N][$];
  exp_cmd_t exp_cmd_q[$];
  exp_w_t   exp_w_q[$];
  int       exp_rd_q[$];
  logic [AW-1:0] dmc_rd_q[$];

  int checks = 0, errors = 0;
  int stall_cnt = 0, rd_beat = 0, cyc_n = 0;
  int n_rd_acc = 0, n_ends = 0, last_acc_ends = 0, en_cycles = 0;
  int wy_cnt[N];
  bit wdf_toggle = 0, rd_ret_en = 1, orphan_req = 0, rd_real = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_v_i[i] = (rq_q[i].size() > 0);
      req_cmd_i[i*3 +: 3] = 3'd0;
      req_addr_i[i*AW +: AW] = '0;
      if (req_v_i[i]) begin
        req_cmd_i[i*3 +: 3]    = rq_q[i][0].cmd;
        req_addr_i[i*AW +: AW] = rq_q[i][0].addr;
      end
      req_wdata_v_i[i] = (bq[i].size() > 0);
      req_wdata_i[i*DW +: DW] = '0;
      req_wmask_i[i*MW +: MW] = '0;
      if (req_wdata_v_i[i]) begin
        req_wdata_i[i*DW +: DW] = bq[i][0].d;
        req_wmask_i[i*MW +: MW] = bq[i][0].m;
      end
    end
    app_rdy_i     = (stall_cnt == 0);
    app_wdf_rdy_i = wdf_toggle ? ((cyc_n % 2) == 0) : 1'b1;
    rd_real = 0;
    app_rd_data_valid_i = 1'b0;
    app_rd_data_end_i   = 1'b0;
    app_rd_data_i       = '0;
    if (orphan_req) begin
      app_rd_data_valid_i = 1'b1;
      app_rd_data_end_i   = 1'b1;
      app_rd_data_i       = 32'hDEAD_BEEF;
    end else if (rd_ret_en && dmc_rd_q.size() > 0) begin
      rd_real = 1;
      app_rd_data_valid_i = 1'b1;
      app_rd_data_end_i   = (rd_beat == BL - 1);
      app_rd_data_i       = {dmc_rd_q[0][15:0], 16'(rd_beat)};
    end
  endtask

  // One clock: check at negedge, then update requester/DMC models after posedge.
  task automatic cyc();
    logic [N-1:0] ys, wys;
    @(negedge clk_i);
    if (app_en_o) begin
      en_cycles++;
      if (exp_cmd_q.size() == 0) chk("unexpected_cmd", 1, 0);
      else begin
        chk("cmd_addr", app_addr_o, exp_cmd_q[0].addr);
        chk("cmd_op", app_cmd_o, exp_cmd_q[0].cmd);
        if (app_rdy_i) begin
          chk("req_yumi", req_yumi_o, N'(1) << exp_cmd_q[0].id);
          if (exp_cmd_q[0].cmd != e_app_wr) begin
            dmc_rd_q.push_back(exp_cmd_q[0].addr);
            n_rd_acc++;
            last_acc_ends = n_ends;
          end
          void'(exp_cmd_q.pop_front());
        end
      end
      if (stall_cnt > 0) stall_cnt--;
    end else chk("yumi_without_en", req_yumi_o, 0);
    if (app_wdf_wren_o && app_wdf_rdy_i) begin
      if (exp_w_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        chk("wdf_data", app_wdf_data_o, exp_w_q[0].d);
        chk("wdf_mask", app_wdf_mask_o, exp_w_q[0].m);
        chk("wdf_end", app_wdf_end_o, exp_w_q[0].last);
        chk("wdata_yumi", req_wdata_yumi_o, N'(1) << exp_w_q[0].id);
        void'(exp_w_q.pop_front());
      end
    end
    for (int i = 0; i < N; i++) if (req_wdata_yumi_o[i]) wy_cnt[i]++;
    if (app_rd_data_valid_i) begin
      if (!rd_real) chk("orphan_rd_v", rd_data_v_o, 0);
      else if (exp_rd_q.size() == 0) chk("unexpected_rd", 1, 0);
      else begin
        chk("rd_v", rd_data_v_o, N'(1) << exp_rd_q[0]);
        chk("rd_data", rd_data_o, {dmc_rd_q[0][15:0], 16'(rd_beat)});
        chk("rd_end", rd_data_end_o, rd_beat == BL - 1);
        if (rd_beat == BL - 1) begin
          void'(exp_rd_q.pop_front());
          n_ends++;
        end
      end
    end
    ys  = req_yumi_o;
    wys = req_wdata_yumi_o;
    @(posedge clk_i);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (ys[i] && rq_q[i].size() > 0) void'(rq_q[i].pop_front());
      if (wys[i] && bq[i].size() > 0) void'(bq[i].pop_front());
    end
    if (rd_real) begin
      if (rd_beat == BL - 1) begin
        rd_beat = 0;
        void'(dmc_rd_q.pop_front());
      end else rd_beat++;
    end
    orphan_req = 0;
    drive();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (rq_q[i].size() != 0 || bq[i].size() != 0) return 0;
    return exp_cmd_q.size() == 0 && exp_w_q.size() == 0 && exp_rd_q.size() == 0 &&
           dmc_rd_q.size() == 0;
  endfunction

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (!all_idle() && n < max) begin cyc(); n++; end
    chk({tag, "_timeout"}, n < max, 1);
  endtask

  task automatic wait_cmds(input string tag, input int max);
    int n = 0;
    while (exp_cmd_q.size() != 0 && n < max) begin cyc(); n++; end
    chk({tag, "_timeout"}, n < max, 1);
  endtask

  task automatic add_rd(input int id, input logic [AW-1:0] a);
    rq_q[id].push_back('{e_app_rd, a});
    exp_cmd_q.push_back('{id, e_app_rd, a});
    exp_rd_q.push_back(id);
  endtask

  task automatic add_wr(input int id, input logic [AW-1:0] a, input logic [DW-1:0] base);
    logic [DW-1:0] d;
    rq_q[id].push_back('{e_app_wr, a});
    exp_cmd_q.push_back('{id, e_app_wr, a});
    for (int b = 0; b < BL; b++) begin
      d = base + DW'(b);
      bq[id].push_back('{d, MW'(b)});
      exp_w_q.push_back('{id, d, MW'(b), b == BL - 1});
    end
  endtask

  initial begin
    int ord[4];
    int base, ends_base, n;
    reset_i = 1'b1;
    init_calib_complete_i = 1'b0;
    refresh_in_progress_i = 1'b0;
    for (int i = 0; i < N; i++) wy_cnt[i] = 0;
    drive();
    #23;
    chk("rst_yumi", req_yumi_o, 0);
    chk("rst_wdata_yumi", req_wdata_yumi_o, 0);
    chk("rst_app_en", app_en_o, 0);
    chk("rst_wren", app_wdf_wren_o, 0);
    chk("rst_wdf_end", app_wdf_end_o, 0);
    chk("rst_rd_v", rd_data_v_o, 0);
    chk("rst_orphan", rd_orphan_o, 0);
    chk("rst_addr", app_addr_o, 0);
    chk("rst_cmd", app_cmd_o, 0);
    chk("rst_wdf_data", app_wdf_data_o, 0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Pending read must wait for calibration and for refresh to finish.
    rq_q[1].push_back('{e_app_rd, 28'h8});
    drive();
    repeat (5) cyc();
    init_calib_complete_i = 1'b1;
    refresh_in_progress_i = 1'b1;
    repeat (5) cyc();
    chk("gated_no_cmd", en_cycles, 0);
    exp_cmd_q.push_back('{1, e_app_rd, 28'h8});
    exp_rd_q.push_back(1);
    refresh_in_progress_i = 1'b0;
    wait_idle("calib_rd", 100);

    en_cycles = 0;
    wy_cnt[2] = 0;
    add_wr(2, 28'h100, 32'hA0);
    drive();
    wait_idle("wr2", 100);
    chk("wr2_en_cycles", en_cycles, 1);
    chk("wr2_beats", wy_cnt[2], BL);

    // Read from 3 leaves the pointer at 3, so the next round runs 0,1,3 twice.
    add_rd(3, 28'h30);
    drive();
    wait_idle("rd3", 100);
    add_rd(0, 28'h10); add_rd(1, 28'h20); add_rd(3, 28'h30);
    add_rd(0, 28'h11); add_rd(1, 28'h21); add_rd(3, 28'h31);
    drive();
    wait_idle("rr_rounds", 300);

    rd_ret_en = 0;
    ord = '{3, 0, 2, 1};
    foreach (ord[k]) begin
      add_rd(ord[k], AW'(32'h40 + ord[k]));
      drive();
      wait_cmds("ord_issue", 50);
    end
    rd_ret_en = 1;
    drive();
    wait_idle("ord_return", 200);

    rd_ret_en = 0;
    base = n_rd_acc;
    for (int k = 0; k < 9; k++) add_rd(1, AW'(32'h200 + k));
    drive();
    repeat (40) cyc();
    chk("full_accepted", n_rd_acc - base, 8);
    chk("full_no_en", app_en_o, 0);
    chk("full_pending", exp_cmd_q.size(), 1);
    ends_base = n_ends;
    rd_ret_en = 1;
    drive();
    wait_cmds("full_ninth", 100);
    chk("ninth_after_end", last_acc_ends > ends_base, 1);
    wait_idle("full_drain", 300);

    en_cycles = 0;
    wy_cnt[0] = 0;
    stall_cnt = 5;
    wdf_toggle = 1;
    add_wr(0, 28'h300, 32'hB0);
    drive();
    wait_idle("stall_wr", 200);
    chk("stall_en_cycles", en_cycles, 6);
    chk("stall_beats", wy_cnt[0], BL);
    wdf_toggle = 0;

    chk("orphan_pre", rd_orphan_o, 0);
    orphan_req = 1;
    drive();
    cyc();
    repeat (3) cyc();
    chk("orphan_sticky", rd_orphan_o, 1);

    wy_cnt[3] = 0;
    add_wr(3, 28'h400, 32'hC0);
    drive();
    n = 0;
    while (wy_cnt[3] < 3 && n < 50) begin cyc(); n++; end
    chk("mid_burst_reached", n < 50, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("mid_rst_wren", app_wdf_wren_o, 0);
    chk("mid_rst_wdata_yumi", req_wdata_yumi_o, 0);
    chk("mid_rst_wdf_end", app_wdf_end_o, 0);
    chk("mid_rst_app_en", app_en_o, 0);
    chk("mid_rst_orphan", rd_orphan_o, 0);
    for (int i = 0; i < N; i++) begin rq_q[i].delete(); bq[i].delete(); end
    exp_cmd_q.delete(); exp_w_q.delete(); exp_rd_q.delete(); dmc_rd_q.delete();
    rd_beat = 0; stall_cnt = 0;
    drive();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    // Pointer is back at 0, so requester 1 goes before requester 0.
    add_rd(1, 28'h510);
    add_rd(0, 28'h500);
    drive();
    wait_idle("post_rst", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
